// File: rtl/mem_responder_pkg.sv
// Shared memory-map constants and region decode for the 6502 bus responder.
// Also carries the reset-vector addresses that the core uses for its first fetch.
package mem_responder_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hF000;
    localparam logic [15:0] IO_DATA_OFS     = 16'd0;
    localparam logic [15:0] IO_STATUS_OFS   = 16'd1;

    localparam int OVF_BIT   = 7;
    localparam int FULL_BIT  = 6;
    localparam int EMPTY_BIT = 5;

    localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
    localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_ROM,
        REG_IO_DATA,
        REG_IO_STATUS
    } region_e;

    // The I/O window is checked first so it stays reachable even if a wide ROM overlaps it.
    function automatic region_e decode_region(
        input logic [15:0] addr,
        input int          ram_aw,
        input int          rom_aw,
        input logic [15:0] io_base
    );
        region_e r;
        r = REG_NONE;
        if (addr == io_base + IO_DATA_OFS)
            r = REG_IO_DATA;
        else if (addr == io_base + IO_STATUS_OFS)
            r = REG_IO_STATUS;
        else if ({16'd0, addr} < (32'd1 << ram_aw))
            r = REG_RAM;
        else if ({16'd0, addr} >= (32'h0001_0000 - (32'd1 << rom_aw)))
            r = REG_ROM;
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_sync_fifo.sv
// Single-clock FIFO behind the memory-mapped output port.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head reads zero while empty so a freshly reset port shows 8'h00.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the 6502 core: RAM, loader-written ROM and a FIFO-backed
// output port, with a preload path that works while the core is held in reset.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          RAM_AW     = 11,
    parameter int          ROM_AW     = 11,
    parameter logic [15:0] IO_BASE    = IO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  wr_data,
    input  logic        wr_enable,
    output logic [7:0]  rd_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        io_valid,
    input  logic        io_ready,
    output logic [7:0]  io_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0] ram [2**RAM_AW];
    logic [7:0] rom [2**ROM_AW];

    region_e    core_region;
    region_e    ld_region;
    logic       core_we;
    logic       ld_fire;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0] fifo_head;
    logic       ovf;
    logic [7:0] last_data;
    logic [7:0] status;

    assign core_region = decode_region(address, RAM_AW, ROM_AW, IO_BASE);
    assign ld_region   = decode_region(ld_addr, RAM_AW, ROM_AW, IO_BASE);

    // A core write issued while reset is asserted is discarded.
    assign core_we  = wr_enable & resetn;
    assign ld_ready = ~wr_enable;
    assign ld_fire  = ld_valid & ld_ready;

    always_ff @(posedge clk) begin
        if (core_we && core_region == REG_RAM)
            ram[address[RAM_AW-1:0]] <= wr_data;
        else if (ld_fire && ld_region == REG_RAM)
            ram[ld_addr[RAM_AW-1:0]] <= ld_data;
        if (ld_fire && ld_region == REG_ROM)
            rom[ld_addr[ROM_AW-1:0]] <= ld_data;
    end

    assign fifo_push = core_we & (core_region == REG_IO_DATA);
    assign fifo_pop  = io_valid & io_ready;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign io_valid = ~fifo_empty;
    assign io_data  = fifo_head;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf       <= 1'b0;
            last_data <= 8'h00;
        end else begin
            if (fifo_push) begin
                last_data <= wr_data;
                if (fifo_full && !fifo_pop)
                    ovf <= 1'b1;
            end
            if (core_we && core_region == REG_IO_STATUS && wr_data[OVF_BIT])
                ovf <= 1'b0;
        end
    end

    always_comb begin
        status            = 8'h00;
        status[OVF_BIT]   = ovf;
        status[FULL_BIT]  = fifo_full;
        status[EMPTY_BIT] = fifo_empty;
        status[2:0]       = 3'(fifo_count);
    end

    always_comb begin
        rd_data = 8'h00;
        case (core_region)
            REG_RAM:       rd_data = ram[address[RAM_AW-1:0]];
            REG_ROM:       rd_data = rom[address[ROM_AW-1:0]];
            REG_IO_DATA:   rd_data = last_data;
            REG_IO_STATUS: rd_data = status;
            default:       rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed boot/FIFO/collision/reset scenarios
// followed by randomized traffic compared each cycle against a flat memory + queue model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        wr_enable;
    logic [7:0]  rd_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        io_valid;
    logic        io_ready;
    logic [7:0]  io_data;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .address   (address),
        .wr_data   (wr_data),
        .wr_enable (wr_enable),
        .rd_data   (rd_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .io_valid  (io_valid),
        .io_ready  (io_ready),
        .io_data   (io_data)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [65536];
    logic [7:0] q [$];
    logic       m_ovf;
    logic [7:0] m_last;
    bit         preloaded;

    function automatic bit is_mem(input logic [15:0] a);
        return (a < 16'h0800) || (a >= 16'hF800);
    endfunction

    function automatic logic [7:0] exp_status();
        int n;
        n = q.size();
        return {m_ovf, (n == 4), (n == 0), 2'b00, 3'(n)};
    endfunction

    function automatic logic [7:0] exp_rd(input logic [15:0] a);
        if (a == 16'hF000) return m_last;
        if (a == 16'hF001) return exp_status();
        if (is_mem(a)) return mem_m[a];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_last = 8'h00;
    endtask

    // Model advances on the active edge from the inputs that were stable before it.
    task automatic model_update();
        int sz;
        bit pop;
        sz = q.size();
        if (resetn) begin
            pop = (sz != 0) && io_ready;
            if (pop) q.delete(0);
            if (wr_enable) begin
                if (address < 16'h0800) begin
                    mem_m[address] = wr_data;
                end else if (address == 16'hF000) begin
                    m_last = wr_data;
                    if (sz < 4 || pop) q.push_back(wr_data);
                    else m_ovf = 1'b1;
                end else if (address == 16'hF001 && wr_data[7]) begin
                    m_ovf = 1'b0;
                end
            end
        end
        if (ld_valid && !wr_enable && is_mem(ld_addr))
            mem_m[ld_addr] = ld_data;
    endtask

    task automatic compare();
        chk("io_valid", io_valid, (q.size() != 0));
        chk("io_data", io_data, (q.size() != 0) ? q[0] : 8'h00);
        chk("ld_ready", ld_ready, !wr_enable);
        if (preloaded)
            chk("rd_data", rd_data, exp_rd(address));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic core_write(input logic [15:0] a, input logic [7:0] d);
        address   = a;
        wr_data   = d;
        wr_enable = 1'b1;
        step();
        wr_enable = 1'b0;
    endtask

    task automatic reset_pulse();
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_io_valid", io_valid, 1'b0);
        step();
        resetn = 1'b1;
    endtask

    function automatic logic [15:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: return 16'($urandom_range(0, 16'h07FF));
            3, 4:    return 16'($urandom_range(16'hF800, 16'hFFFF));
            5, 6:    return 16'hF000;
            7:       return 16'hF001;
            8:       return 16'($urandom_range(16'h0800, 16'hEFFF));
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        resetn    = 1'b1;
        address   = 16'h0000;
        wr_data   = 8'h00;
        wr_enable = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = 16'h0000;
        ld_data   = 8'h00;
        io_ready  = 1'b0;
        preloaded = 1'b0;
        model_reset();
        #2 resetn = 1'b0;
        #1;
        chk("reset_io_valid", io_valid, 1'b0);
        chk("reset_io_data", io_data, 8'h00);

        // Images go in while the core is still held in reset.
        @(negedge clk);
        ld_valid = 1'b1;
        for (int a = 0; a < 16'h0800; a++) begin
            ld_addr = 16'(a);
            ld_data = 8'(a) ^ 8'h3C;
            step();
        end
        for (int a = 16'hF800; a <= 16'hFFFF; a++) begin
            ld_addr = 16'(a);
            ld_data = 8'(a) ^ 8'hA5;
            step();
        end
        ld_addr = 16'hFFFC; ld_data = 8'h00; step();
        ld_addr = 16'hFFFD; ld_data = 8'hF8; step();
        ld_valid  = 1'b0;
        preloaded = 1'b1;
        address   = 16'hF001;
        step();
        chk("status_in_reset", rd_data, 8'h20);
        resetn = 1'b1;
        step();

        address = 16'hFFFC; #1;
        chk("boot_vec_lo", rd_data, 8'h00);
        step();
        address = 16'hFFFD; #1;
        chk("boot_vec_hi", rd_data, 8'hF8);
        step();

        core_write(16'h0123, 8'h5A);
        address = 16'h0123; #1;
        chk("ram_rw", rd_data, 8'h5A);
        core_write(16'hF900, 8'h77);
        address = 16'hF900; #1;
        chk("rom_protect", rd_data, 8'hA5);
        core_write(16'h9000, 8'h66);
        address = 16'h9000; #1;
        chk("unmapped_rd", rd_data, 8'h00);
        step();

        io_ready = 1'b0;
        for (int d = 8'h41; d <= 8'h45; d++) core_write(16'hF000, 8'(d));
        address = 16'hF001; #1;
        chk("fill_status", rd_data, 8'hC4);
        address = 16'hF000; #1;
        chk("last_data", rd_data, 8'h45);
        io_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("drain_order", io_data, 8'(8'h41 + i));
            step();
        end
        io_ready = 1'b0;
        address = 16'hF001; #1;
        chk("drained_status", rd_data, 8'hA0);

        core_write(16'hF001, 8'h80);
        for (int d = 8'h10; d <= 8'h13; d++) core_write(16'hF000, 8'(d));
        address = 16'hF001; #1;
        chk("full_status", rd_data, 8'h44);
        io_ready = 1'b1;
        core_write(16'hF000, 8'h99);
        io_ready = 1'b0;
        address = 16'hF001; #1;
        chk("pushpop_full_status", rd_data, 8'h44);
        io_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("pushpop_order", io_data, (i == 3) ? 8'h99 : 8'(8'h11 + i));
            step();
        end
        io_ready = 1'b0;

        address   = 16'h0020;
        wr_data   = 8'h22;
        wr_enable = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = 16'h0010;
        ld_data   = 8'h11;
        #1 chk("collide_ld_ready", ld_ready, 1'b0);
        step();
        wr_enable = 1'b0;
        #1 chk("stall_ld_ready", ld_ready, 1'b1);
        step();
        ld_valid = 1'b0;
        address = 16'h0010; #1;
        chk("loader_after_stall", rd_data, 8'h11);
        address = 16'h0020; #1;
        chk("core_in_collision", rd_data, 8'h22);

        for (int d = 8'h31; d <= 8'h33; d++) core_write(16'hF000, 8'(d));
        address = 16'hF001; #1;
        chk("pre_reset_status", rd_data, 8'h03);
        reset_pulse();
        #1 chk("post_reset_status", rd_data, 8'h20);
        address = 16'h0123; #1;
        chk("ram_survives_reset", rd_data, 8'h5A);
        step();

        for (int i = 0; i < 3000; i++) begin
            address   = pick_addr();
            wr_data   = 8'($urandom());
            wr_enable = ($urandom_range(0, 9) < 3);
            ld_valid  = ($urandom_range(0, 9) < 3);
            ld_addr   = pick_addr();
            ld_data   = 8'($urandom());
            io_ready  = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 199) == 0) reset_pulse();
            else step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
